// File: rtl/fetch_decode_unit.sv
// Instruction fetch/decode front end: drives pc to instruction memory, decodes the
// returned word, resolves JMP/JMPZ/END locally and issues everything else to the
// execute datapath over a valid/done handshake.
module fetch_decode_unit #(
  parameter int unsigned AddrW  = 6,
  parameter int unsigned InstrW = 20,
  parameter int unsigned CntW   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [InstrW-1:0] instr_i,
  input  logic              zero_flag_i,
  input  logic              exec_done_i,
  output logic [AddrW-1:0]  pc_o,
  output logic              issue_valid_o,
  output logic [3:0]        op_o,
  output logic [3:0]        reg_a_o,
  output logic [3:0]        reg_b_o,
  output logic [11:0]       imm_o,
  output logic              halted_o,
  output logic              illegal_op_o,
  output logic [CntW-1:0]   retired_o
);

  localparam logic [3:0] OpJmpz = 4'd11;
  localparam logic [3:0] OpJmp  = 4'd12;
  localparam logic [3:0] OpEnd  = 4'd14;

  typedef enum logic [1:0] {StFetch, StDecode, StIssue, StHalt} state_e;

  state_e            state_q;
  logic [AddrW-1:0]  pc_q;
  logic              issue_valid_q;
  logic [3:0]        op_q;
  logic [3:0]        reg_a_q;
  logic [3:0]        reg_b_q;
  logic [11:0]       imm_q;
  logic              halted_q;
  logic              illegal_op_q;
  logic [CntW-1:0]   retired_q;

  logic [3:0]        opcode;
  logic [AddrW-1:0]  target;
  logic [AddrW-1:0]  pc_inc;
  logic [CntW-1:0]   retired_inc;
  logic              is_issued;

  assign opcode      = instr_i[InstrW-1 -: 4];
  assign target      = instr_i[15 -: AddrW];
  assign pc_inc      = pc_q + AddrW'(1);
  assign retired_inc = retired_q + CntW'(1);

  // Classify opcodes that are handed to the execute datapath.
  always_comb begin
    is_issued = 1'b0;
    case (opcode)
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd13: is_issued = 1'b1;
      default: is_issued = 1'b0;
    endcase
  end

  // Fetch/decode/issue FSM with all outputs registered; reset wins in every state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StFetch;
      pc_q          <= '0;
      issue_valid_q <= 1'b0;
      op_q          <= '0;
      reg_a_q       <= '0;
      reg_b_q       <= '0;
      imm_q         <= '0;
      halted_q      <= 1'b0;
      illegal_op_q  <= 1'b0;
      retired_q     <= '0;
    end else begin
      illegal_op_q <= 1'b0;
      case (state_q)
        StFetch: state_q <= StDecode;
        StDecode: begin
          if (is_issued) begin
            op_q          <= opcode;
            reg_a_q       <= instr_i[15:12];
            reg_b_q       <= instr_i[11:8];
            imm_q         <= instr_i[11:0];
            issue_valid_q <= 1'b1;
            state_q       <= StIssue;
          end else if (opcode == OpJmp) begin
            pc_q      <= target;
            retired_q <= retired_inc;
            state_q   <= StFetch;
          end else if (opcode == OpJmpz) begin
            pc_q      <= zero_flag_i ? target : pc_inc;
            retired_q <= retired_inc;
            state_q   <= StFetch;
          end else if (opcode == OpEnd) begin
            halted_q <= 1'b1;
            state_q  <= StHalt;
          end else begin
            illegal_op_q <= 1'b1;
            pc_q         <= pc_inc;
            state_q      <= StFetch;
          end
        end
        StIssue: begin
          if (exec_done_i) begin
            issue_valid_q <= 1'b0;
            pc_q          <= pc_inc;
            retired_q     <= retired_inc;
            state_q       <= StFetch;
          end
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StFetch;
      endcase
    end
  end

  assign pc_o          = pc_q;
  assign issue_valid_o = issue_valid_q;
  assign op_o          = op_q;
  assign reg_a_o       = reg_a_q;
  assign reg_b_o       = reg_b_q;
  assign imm_o         = imm_q;
  assign halted_o      = halted_q;
  assign illegal_op_o  = illegal_op_q;
  assign retired_o     = retired_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: registered instruction memory, instruction-level
// reference model compared every cycle, plus directed literal checkpoints.
module tb_fetch_decode_unit;

  localparam int PF = 0, PD = 1, PI = 2, PH = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exec_done;
  logic        zero_flag;
  logic [19:0] instr;
  logic [5:0]  pc;
  logic        issue_valid;
  logic [3:0]  op, reg_a, reg_b;
  logic [11:0] imm;
  logic        halted, illegal_op;
  logic [15:0] retired;

  always #5 clk = ~clk;

  fetch_decode_unit dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .instr_i      (instr),
    .zero_flag_i  (zero_flag),
    .exec_done_i  (exec_done),
    .pc_o         (pc),
    .issue_valid_o(issue_valid),
    .op_o         (op),
    .reg_a_o      (reg_a),
    .reg_b_o      (reg_b),
    .imm_o        (imm),
    .halted_o     (halted),
    .illegal_op_o (illegal_op),
    .retired_o    (retired)
  );

  // Instruction memory returns ram[pc] one clock later.
  logic [19:0] ram [64];
  always @(posedge clk) instr <= ram[pc];

  int n_err = 0;
  int n_checks = 0;
  int ill_cnt = 0;
  bit en = 0;
  bit hold = 0;
  int iss_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: executes the instruction at the modelled pc.
  int          m_phase = PF;
  logic [5:0]  m_pc = '0;
  logic [15:0] m_ret = '0;
  logic        m_iv = 1'b0, m_halt = 1'b0, m_ill = 1'b0;
  logic [3:0]  m_op = '0, m_ra = '0, m_rb = '0;
  logic [11:0] m_imm = '0;
  logic [19:0] m_word;
  assign m_word = ram[m_pc];

  function automatic bit issued_op(input logic [3:0] o);
    return (o >= 4'd2 && o <= 4'd10) || o == 4'd13;
  endfunction

  always @(posedge clk) begin
    m_ill <= 1'b0;
    if (!rst_n) begin
      m_phase <= PF; m_pc <= '0; m_ret <= '0; m_iv <= 1'b0; m_halt <= 1'b0;
      m_op <= '0; m_ra <= '0; m_rb <= '0; m_imm <= '0;
    end else begin
      case (m_phase)
        PF: m_phase <= PD;
        PD: begin
          if (issued_op(m_word[19:16])) begin
            m_op <= m_word[19:16]; m_ra <= m_word[15:12]; m_rb <= m_word[11:8];
            m_imm <= m_word[11:0]; m_iv <= 1'b1; m_phase <= PI;
          end else if (m_word[19:16] == 4'd12 || m_word[19:16] == 4'd11) begin
            m_ret <= m_ret + 16'd1;
            m_pc  <= (m_word[19:16] == 4'd12 || zero_flag) ? m_word[15:10] : m_pc + 6'd1;
            m_phase <= PF;
          end else if (m_word[19:16] == 4'd14) begin
            m_halt <= 1'b1; m_phase <= PH;
          end else begin
            m_ill <= 1'b1; m_pc <= m_pc + 6'd1; m_phase <= PF;
          end
        end
        PI: if (exec_done) begin
          m_iv <= 1'b0; m_pc <= m_pc + 6'd1; m_ret <= m_ret + 16'd1; m_phase <= PF;
        end
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (en) begin
      chk("pc", 32'(pc), 32'(m_pc));
      chk("issue_valid", 32'(issue_valid), 32'(m_iv));
      chk("op", 32'(op), 32'(m_op));
      chk("reg_a", 32'(reg_a), 32'(m_ra));
      chk("reg_b", 32'(reg_b), 32'(m_rb));
      chk("imm", 32'(imm), 32'(m_imm));
      chk("halted", 32'(halted), 32'(m_halt));
      chk("illegal_op", 32'(illegal_op), 32'(m_ill));
      chk("retired", 32'(retired), 32'(m_ret));
      if (illegal_op === 1'b1) ill_cnt++;
    end
  end

  function automatic int stall_for(input logic [5:0] a);
    return (a == 6'd1) ? 5 : (a == 6'd21) ? 2 : 0;
  endfunction

  // Execute-side responder and zero flag; both are randomised where they must be ignored.
  initial begin
    exec_done = 1'b0;
    zero_flag = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (m_phase == PI) begin
        exec_done = !hold && (iss_cnt >= stall_for(m_pc));
        iss_cnt++;
      end else begin
        exec_done = 1'($urandom_range(0, 1));
        iss_cnt = 0;
      end
      if (m_phase == PD) zero_flag = (m_pc == 6'd12);
      else zero_flag = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_pc(input logic [5:0] t);
    int n = 0;
    while (pc !== t && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pc", 32'(pc), 32'(t));
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) ram[i] = 20'h00000;
    ram[0]  = 20'h31000;  // WRITE Ax 0
    ram[1]  = 20'h55600;  // MUL Cx Cy, back-pressured
    ram[2]  = 20'hC8C00;  // JMP 35
    ram[35] = 20'hC3000;  // JMP 12
    ram[12] = 20'hB8400;  // JMPZ 33, zero_flag=1
    ram[33] = 20'hC5000;  // JMP 20
    ram[20] = 20'hB8400;  // JMPZ 33, zero_flag=0 -> 21
    ram[21] = 20'h81200;  // ADD Ax Ay
    ram[22] = 20'h10000;  // illegal opcode 1
    ram[23] = 20'hCFC00;  // JMP 63
    ram[63] = 20'hF0000;  // illegal opcode 15, wraps to 0

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    en = 1;
    rst_n = 1'b1;

    @(negedge clk); chk("lit_pc_c0", 32'(pc), 0); chk("lit_iv_c0", 32'(issue_valid), 0);
    @(negedge clk); chk("lit_pc_c1", 32'(pc), 0); chk("lit_iv_c1", 32'(issue_valid), 0);
    @(negedge clk);
    chk("lit_iv_c2", 32'(issue_valid), 1);
    chk("lit_op_c2", 32'(op), 3);
    chk("lit_rega_c2", 32'(reg_a), 1);
    chk("lit_imm_c2", 32'(imm), 0);
    @(negedge clk);
    chk("lit_pc_c3", 32'(pc), 1);
    chk("lit_ret_c3", 32'(retired), 1);
    chk("lit_iv_c3", 32'(issue_valid), 0);
    ram[0] = 20'hE0000;  // END once the run wraps back to address 0

    wait_pc(6'd2);
    chk("lit_ret_after_mul", 32'(retired), 2);
    wait_pc(6'd21);
    chk("lit_ret_after_jmpz", 32'(retired), 7);

    n = 0;
    while (halted !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("lit_halted", 32'(halted), 1);
    chk("lit_ret_halt", 32'(retired), 9);
    chk("lit_ill_cnt", 32'(ill_cnt), 2);
    chk("lit_pc_halt", 32'(pc), 0);
    repeat (20) begin
      @(negedge clk);
      chk("halt_pc", 32'(pc), 0);
      chk("halt_iv", 32'(issue_valid), 0);
      chk("halt_hold", 32'(halted), 1);
    end

    ram[0] = 20'h31000;
    hold = 1;
    pulse_reset();
    @(negedge clk);
    chk("lit_rst_pc", 32'(pc), 0);
    chk("lit_rst_halted", 32'(halted), 0);
    chk("lit_rst_ret", 32'(retired), 0);

    n = 0;
    while (issue_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("lit_stuck_iv", 32'(issue_valid), 1);
    chk("lit_stuck_pc", 32'(pc), 0);
    pulse_reset();
    hold = 0;
    @(negedge clk);
    chk("lit_midrst_iv", 32'(issue_valid), 0);
    chk("lit_midrst_pc", 32'(pc), 0);

    n = 0;
    while (retired !== 16'd1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("lit_restart_ret", 32'(retired), 1);
    chk("lit_restart_pc", 32'(pc), 1);
    repeat (60) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode_unit.md
# fetch_decode_unit

Instruction fetch and decode front end for the processor. It drives the 6-bit program counter into the instruction memory and captures the registered 20-bit instruction returned one clock later. It decodes the opcode and operand fields and resolves JMP, JMPZ and END locally. All other instructions are issued to the execute datapath over a valid/done handshake.

## Interface
- ADDR_W, 6, PC / instruction-memory address width
- INSTR_W, 20, instruction word width
- CNT_W, 16, retired-instruction counter width
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low; one clock, sampled on rising edge of clk
- instr_in  input  INSTR_W  instruction word from instruction memory, valid the cycle after pc is sampled
- zero_flag  input  1  ALU zero flag, consulted only by JMPZ
- exec_done  input  1  execute datapath has completed the issued instruction
- pc  output  ADDR_W  instruction address to instruction memory
- issue_valid  output  1  decoded instruction presented to execute datapath
- op  output  4  opcode, instr[19:16]
- reg_a  output  4  first register field, instr[15:12]
- reg_b  output  4  second register field, instr[11:8]
- imm  output  12  immediate / memory address, instr[11:0]
- halted  output  1  END executed; fetch stopped
- illegal_op  output  1  one-cycle pulse on an undefined opcode
- retired  output  CNT_W  count of completed instructions

## Operation
- Opcode map:
  - 2 RST; 3 WRITE; 4 LOADI; 5 MUL; 6 LOAD; 7 MV; 8 ADD; 9 INC; 10 SUB; 13 STORE are issued to the execute datapath.
  - 11 JMPZ, 12 JMP and 14 END are handled internally.
  - 0, 1 and 15 are illegal.
- Jump target is instr[15:10], 6 bits, absolute.
- Register codes are passed through undecoded: Ax=1, Ay=2, Az=3, Rx=4, Cx=5, Cy=6, TR1=7, TR2=8, Vx=9, Vy=10, I=11, J=12, K=13, Sy=14.
- States: FETCH, DECODE, ISSUE, HALT.
  - FETCH: pc is stable while memory captures ram[pc]. Always goes to DECODE next.
  - DECODE: instr_in is valid. Behaviour depends on the opcode:
    - Issued class: latch op/reg_a/reg_b/imm into output registers, go to ISSUE.
    - JMP: pc <= target, go to FETCH.
    - JMPZ: pc <= zero_flag ? target : pc+1, go to FETCH.
    - END: go to HALT.
    - Illegal: pulse illegal_op, pc <= pc+1, go to FETCH.
  - ISSUE: issue_valid=1 and fields held stable.
    - When exec_done is sampled 1: pc <= pc+1, go to FETCH.
    - Otherwise remain in ISSUE.
  - HALT: halted=1, pc frozen, issue_valid=0. Only reset leaves HALT.
- retired counter:
  - Increments by 1 on each exec_done acceptance in ISSUE.
  - Increments by 1 on each JMP or JMPZ resolution in DECODE.
  - END and illegal opcodes do not count.
  - Wraps modulo 2^CNT_W.
- pc+1 wraps modulo 2^ADDR_W; 63 goes to 0.
- exec_done outside ISSUE is ignored.
- zero_flag outside DECODE is ignored.

## Timing
- Reset values: pc=0, state=FETCH, issue_valid=0, op=0, reg_a=0, reg_b=0, imm=0, halted=0, illegal_op=0, retired=0.
- Reset has priority in every state, including mid-ISSUE and HALT. The cycle after rst_n is sampled low, all outputs hold their reset values and the handshake is abandoned.
- Issued instruction latency:
  - issue_valid rises 2 cycles after pc takes a new value (FETCH, DECODE).
  - Minimum 3 cycles per instruction when exec_done=1 on the first ISSUE cycle.
  - The new pc is visible the cycle after exec_done is accepted.
- JMP, JMPZ and illegal opcodes take 2 cycles; issue_valid is never asserted for them.
- illegal_op is high exactly one cycle, the cycle after DECODE.
- issue_valid deasserts the cycle after exec_done is accepted.
- op, reg_a, reg_b and imm change only on DECODE to ISSUE transitions.
- halted rises the cycle after DECODE of END and stays high.

## Test plan
- Reset, then ram[0]=0x31000 (WRITE Ax 0):
  - pc=0 for 2 cycles, then issue_valid=1, op=3, reg_a=1, imm=0x000.
  - exec_done=1 that cycle gives pc=1 and retired=1 next cycle.
- Backpressure: during ISSUE of 0x55600 (MUL Cx Cy), hold exec_done=0 for 5 cycles:
  - issue_valid stays 1; op=5, reg_a=5, reg_b=6; pc unchanged.
  - exec_done=1 then gives pc+1.
- Jumps:
  - pc=35 holding 0xC3000 (JMP 12): pc=12 two cycles later, issue_valid never 1, retired+1.
  - 0xB8400 (JMPZ 33) with zero_flag=1 gives pc=33.
  - Same word with zero_flag=0 at pc=20 gives pc=21.
- 0xE0000 (END):
  - halted=1, pc frozen, issue_valid=0 for 20 cycles.
  - rst_n low one cycle gives pc=0, halted=0, retired=0.
- Illegal 0xF0000 at pc=63:
  - illegal_op high exactly one cycle, pc wraps to 0, retired unchanged.
- Reset mid-ISSUE with exec_done=0:
  - issue_valid=0 and pc=0 the next cycle.
  - Fetch restarts from address 0.
